cache_fill_fsm: RTL and testbench

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

---
 rtl/cache_fill_fsm.sv | 132 +++++++++++++
 tb/tb_cache_fill_fsm.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// Cache block fill controller: on a miss it issues BLOCK_WORDS sequential word reads and streams the returned words into the data array.
// Optional build macro CACHE_FILL_TIMEOUT_EN adds a 32-cycle silent-memory timeout with a fill_error pulse.
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        memory_data_valid,
    input  logic [15:0] memory_data,
    output logic        fsm_busy,
    output logic        memory_enable,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic [15:0] fill_addr,
    output logic [15:0] fill_data,
    output logic        write_tag_array
`ifdef CACHE_FILL_TIMEOUT_EN
    ,
    output logic        fill_error
`endif
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [15:0] OFFSET_MASK = 16'(2 * BLOCK_WORDS - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t           state, state_next;
    logic [15:0]      base, base_next;
    logic [CNT_W-1:0] req_cnt, req_cnt_next;
    logic [CNT_W-1:0] rcv_cnt, rcv_cnt_next;
    logic             last_word;

`ifdef CACHE_FILL_TIMEOUT_EN
    logic [4:0]       idle_cnt, idle_cnt_next;
`endif

    assign last_word = (rcv_cnt == CNT_W'(BLOCK_WORDS - 1));

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_next       = state;
        base_next        = base;
        req_cnt_next     = req_cnt;
        rcv_cnt_next     = rcv_cnt;
        fsm_busy         = 1'b0;
        memory_enable    = 1'b0;
        memory_address   = 16'h0000;
        write_data_array = 1'b0;
        fill_addr        = 16'h0000;
        fill_data        = 16'h0000;
        write_tag_array  = 1'b0;
`ifdef CACHE_FILL_TIMEOUT_EN
        idle_cnt_next    = idle_cnt;
        fill_error       = 1'b0;
`endif

        case (state)
            IDLE: begin
                // Returned words arriving here are stale and dropped on purpose.
                if (miss_detected) begin
                    base_next    = miss_address & ~OFFSET_MASK;
                    req_cnt_next = '0;
                    rcv_cnt_next = '0;
`ifdef CACHE_FILL_TIMEOUT_EN
                    idle_cnt_next = 5'd0;
`endif
                    state_next   = FILL;
                end
            end

            FILL: begin
                fsm_busy = 1'b1;
                if (req_cnt < CNT_W'(BLOCK_WORDS)) begin
                    memory_enable  = 1'b1;
                    memory_address = base + (16'(req_cnt) << 1);
                    req_cnt_next   = req_cnt + CNT_W'(1);
                end
                // Memory returns words in issue order, so rcv_cnt alone locates each word.
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    fill_addr        = base + (16'(rcv_cnt) << 1);
                    fill_data        = memory_data;
                    rcv_cnt_next     = rcv_cnt + CNT_W'(1);
                    if (last_word) begin
                        write_tag_array = 1'b1;
                        state_next      = IDLE;
                    end
                end
`ifdef CACHE_FILL_TIMEOUT_EN
                if (memory_data_valid) begin
                    idle_cnt_next = 5'd0;
                end else if (idle_cnt == 5'd31) begin
                    // 32nd silent cycle: give up without validating the tag.
                    fill_error = 1'b1;
                    state_next = IDLE;
                end else begin
                    idle_cnt_next = idle_cnt + 5'd1;
                end
`endif
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            base    <= 16'h0000;
            req_cnt <= '0;
            rcv_cnt <= '0;
`ifdef CACHE_FILL_TIMEOUT_EN
            idle_cnt <= 5'd0;
`endif
        end else begin
            state   <= state_next;
            base    <= base_next;
            req_cnt <= req_cnt_next;
            rcv_cnt <= rcv_cnt_next;
`ifdef CACHE_FILL_TIMEOUT_EN
            idle_cnt <= idle_cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: latency-configurable memory model, expected request/write queues per fill.
// The timeout scenario is compiled only when CACHE_FILL_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_cache_fill_fsm;

    localparam int BW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        memory_enable;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [15:0] fill_addr;
    logic [15:0] fill_data;
    logic        write_tag_array;
`ifdef CACHE_FILL_TIMEOUT_EN
    logic        fill_error;
`endif

    int checks = 0;
    int failures = 0;

    cache_fill_fsm #(.BLOCK_WORDS(BW)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .memory_enable     (memory_enable),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_addr         (fill_addr),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
`ifdef CACHE_FILL_TIMEOUT_EN
        ,
        .fill_error        (fill_error)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    int          cyc = 0;
    int          latency = 4;
    int          mem_budget = -1;
    logic        force_valid = 1'b0;
    logic [15:0] force_data = 16'h0000;

    logic [15:0] req_log[$];
    int          req_cyc[$];
    logic [15:0] wr_addr_log[$];
    logic [15:0] wr_data_log[$];
    int          wr_cyc_log[$];
    int          tag_cnt, tag_cyc, tag_at_wr, busy_cnt, err_cnt, err_cyc;
    logic        last_busy;

    logic [15:0] exp_req[$];
    logic [15:0] exp_wr_addr[$];
    logic [15:0] exp_wr_data[$];

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic clear_logs();
        req_log.delete(); req_cyc.delete();
        wr_addr_log.delete(); wr_data_log.delete(); wr_cyc_log.delete();
        exp_req.delete(); exp_wr_addr.delete(); exp_wr_data.delete();
        pend.delete();
        tag_cnt = 0; tag_cyc = -1; tag_at_wr = -1; busy_cnt = 0; err_cnt = 0; err_cyc = -1;
        last_busy = 1'b0;
    endtask

    task automatic expect_block(input logic [15:0] miss_addr);
        logic [15:0] blk;
        logic [15:0] a;
        blk = miss_addr & ~16'(2 * BW - 1);
        for (int k = 0; k < BW; k++) begin
            a = blk + 16'(2 * k);
            exp_req.push_back(a);
            exp_wr_addr.push_back(a);
            exp_wr_data.push_back(mem_fn(a));
        end
    endtask

    // One clock cycle: drive memory return, sample DUT at negedge, advance to just after the next posedge.
    task automatic tick();
        if (force_valid) begin
            memory_data_valid = 1'b1;
            memory_data       = force_data;
        end else if (pend.size() > 0 && pend[0].due <= cyc && mem_budget != 0) begin
            memory_data_valid = 1'b1;
            memory_data       = mem_fn(pend[0].addr);
            void'(pend.pop_front());
            if (mem_budget > 0) mem_budget--;
        end else begin
            memory_data_valid = 1'b0;
            memory_data       = 16'h0000;
        end
        @(negedge clk);
        if (memory_enable) begin
            req_log.push_back(memory_address);
            req_cyc.push_back(cyc);
            pend.push_back('{memory_address, cyc + latency});
        end
        if (write_data_array) begin
            wr_addr_log.push_back(fill_addr);
            wr_data_log.push_back(fill_data);
            wr_cyc_log.push_back(cyc);
        end
        if (write_tag_array) begin
            tag_cnt++;
            tag_cyc   = cyc;
            tag_at_wr = wr_addr_log.size();
        end
        if (fsm_busy) busy_cnt++;
        last_busy = fsm_busy;
`ifdef CACHE_FILL_TIMEOUT_EN
        if (fill_error) begin
            err_cnt++;
            err_cyc = cyc;
        end
`endif
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; miss_detected = 1'b1; miss_address = 16'h1236;
        memory_data_valid = 1'b1; memory_data = 16'hBEEF;
        #12;
        checks++; if (fsm_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", fsm_busy); end
        checks++; if (memory_enable !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%b exp=0", memory_enable); end
        checks++; if ({write_data_array, write_tag_array} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {write_data_array, write_tag_array}); end
        checks++; if ({memory_address, fill_addr, fill_data} !== 48'h0) begin failures++; $display("FAIL reset_buses got=%h exp=0", {memory_address, fill_addr, fill_data}); end
        miss_detected = 1'b0; miss_address = 16'h0000; memory_data_valid = 1'b0; memory_data = 16'h0000;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc = 0;
        tick();
        checks++; if (last_busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%b exp=0", last_busy); end
    endtask

    task automatic test_basic_fill();
        int c0;
        logic [15:0] e;
        clear_logs(); latency = 4; mem_budget = -1;
        expect_block(16'h1236);
        c0 = cyc;
        miss_detected = 1'b1; miss_address = 16'h1236;
        tick();
        miss_detected = 1'b0; miss_address = 16'h0000;
        for (int i = 0; i < 40 && tag_cnt < 1; i++) tick();
        tick();
        checks++; if (req_log.size() != BW) begin failures++; $display("FAIL basic_req_count got=%0d exp=%0d", req_log.size(), BW); end
        for (int k = 0; k < BW; k++) begin
            e = exp_req.pop_front();
            checks++; if (k >= req_log.size() || req_log[k] !== e || req_cyc[k] != c0 + 1 + k) begin
                failures++; $display("FAIL basic_req[%0d] got=%h@%0d exp=%h@%0d", k, (k < req_log.size()) ? req_log[k] : 16'h0, (k < req_cyc.size()) ? req_cyc[k] : -1, e, c0 + 1 + k);
            end
        end
        checks++; if (wr_addr_log.size() != BW) begin failures++; $display("FAIL basic_wr_count got=%0d exp=%0d", wr_addr_log.size(), BW); end
        for (int k = 0; k < BW && k < wr_addr_log.size(); k++) begin
            e = exp_wr_addr.pop_front();
            checks++; if (wr_addr_log[k] !== e || wr_data_log[k] !== exp_wr_data[0] || wr_cyc_log[k] != c0 + 5 + k) begin
                failures++; $display("FAIL basic_wr[%0d] got=%h/%h@%0d exp=%h/%h@%0d", k, wr_addr_log[k], wr_data_log[k], wr_cyc_log[k], e, exp_wr_data[0], c0 + 5 + k);
            end
            void'(exp_wr_data.pop_front());
        end
        checks++; if (tag_cnt != 1 || tag_at_wr != BW || tag_cyc != c0 + 12) begin
            failures++; $display("FAIL basic_tag got=cnt%0d/wr%0d@%0d exp=cnt1/wr%0d@%0d", tag_cnt, tag_at_wr, tag_cyc, BW, c0 + 12);
        end
        checks++; if (busy_cnt != 12) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=12", busy_cnt); end
    endtask

    task automatic test_miss_held();
        int t_done;
        logic [15:0] e;
        clear_logs(); latency = 3; mem_budget = -1;
        expect_block(16'h1236);
        expect_block(16'h4000);
        miss_detected = 1'b1; miss_address = 16'h1236;
        tick();
        miss_address = 16'h4000;
        for (int i = 0; i < 40 && tag_cnt < 1; i++) tick();
        t_done = tag_cyc;
        tick();
        checks++; if (last_busy !== 1'b0) begin failures++; $display("FAIL held_idle_gap got=%b exp=0", last_busy); end
        miss_detected = 1'b0; miss_address = 16'h0000;
        for (int i = 0; i < 40 && tag_cnt < 2; i++) tick();
        tick();
        checks++; if (req_log.size() != 2 * BW) begin failures++; $display("FAIL held_req_count got=%0d exp=%0d", req_log.size(), 2 * BW); end
        for (int k = 0; k < 2 * BW && k < req_log.size(); k++) begin
            e = exp_req.pop_front();
            checks++; if (req_log[k] !== e) begin failures++; $display("FAIL held_req[%0d] got=%h exp=%h", k, req_log[k], e); end
        end
        checks++; if (req_cyc.size() <= BW || req_cyc[BW] != t_done + 2) begin
            failures++; $display("FAIL held_restart_cycle got=%0d exp=%0d", (req_cyc.size() > BW) ? req_cyc[BW] : -1, t_done + 2);
        end
        for (int k = 0; k < 2 * BW && k < wr_addr_log.size(); k++) begin
            e = exp_wr_addr.pop_front();
            checks++; if (wr_addr_log[k] !== e || wr_data_log[k] !== exp_wr_data[0]) begin
                failures++; $display("FAIL held_wr[%0d] got=%h/%h exp=%h/%h", k, wr_addr_log[k], wr_data_log[k], e, exp_wr_data[0]);
            end
            void'(exp_wr_data.pop_front());
        end
        checks++; if (tag_cnt != 2 || wr_addr_log.size() != 2 * BW) begin
            failures++; $display("FAIL held_tags got=%0d/%0d exp=2/%0d", tag_cnt, wr_addr_log.size(), 2 * BW);
        end
    endtask

    task automatic test_idle_valid();
        clear_logs();
        memory_data_valid = 1'b1; memory_data = 16'hBEEF;
        #2;
        checks++; if ({write_data_array, write_tag_array} !== 2'b00 || fill_data !== 16'h0000) begin
            failures++; $display("FAIL idle_valid_comb got=%b/%h exp=00/0000", {write_data_array, write_tag_array}, fill_data);
        end
        force_valid = 1'b1; force_data = 16'hBEEF;
        for (int i = 0; i < 4; i++) tick();
        force_valid = 1'b0;
        tick();
        checks++; if (wr_addr_log.size() != 0 || tag_cnt != 0 || busy_cnt != 0 || req_log.size() != 0) begin
            failures++; $display("FAIL idle_valid_ignored got=wr%0d tag%0d busy%0d req%0d exp=all0", wr_addr_log.size(), tag_cnt, busy_cnt, req_log.size());
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [15:0] e;
        clear_logs(); latency = 4; mem_budget = -1;
        expect_block(16'h2A46);
        miss_detected = 1'b1; miss_address = 16'h2A46;
        tick();
        miss_detected = 1'b0; miss_address = 16'h0000;
        for (int i = 0; i < 30 && wr_addr_log.size() < 3; i++) tick();
        for (int k = 0; k < 3 && k < wr_addr_log.size(); k++) begin
            e = exp_wr_addr.pop_front();
            checks++; if (wr_addr_log[k] !== e || wr_data_log[k] !== exp_wr_data[0]) begin
                failures++; $display("FAIL rstmid_wr[%0d] got=%h/%h exp=%h/%h", k, wr_addr_log[k], wr_data_log[k], e, exp_wr_data[0]);
            end
            void'(exp_wr_data.pop_front());
        end
        checks++; if (fsm_busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", fsm_busy); end
        memory_data_valid = 1'b1; memory_data = 16'h7777;
        rst = 1'b1;
        #1;
        checks++; if ({fsm_busy, memory_enable, write_data_array, write_tag_array} !== 4'b0000) begin
            failures++; $display("FAIL rstmid_ctrl got=%b exp=0000", {fsm_busy, memory_enable, write_data_array, write_tag_array});
        end
        checks++; if ({memory_address, fill_addr, fill_data} !== 48'h0) begin
            failures++; $display("FAIL rstmid_buses got=%h exp=0", {memory_address, fill_addr, fill_data});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        cyc++;
        clear_logs();
        force_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            force_data = 16'h1000 + 16'(i);
            tick();
        end
        force_valid = 1'b0;
        tick();
        checks++; if (wr_addr_log.size() != 0 || tag_cnt != 0 || busy_cnt != 0) begin
            failures++; $display("FAIL rstmid_stale got=wr%0d tag%0d busy%0d exp=all0", wr_addr_log.size(), tag_cnt, busy_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] e;
        clear_logs(); latency = 1; mem_budget = -1;
        expect_block(16'hFFFA);
        miss_detected = 1'b1; miss_address = 16'hFFFA;
        tick();
        miss_detected = 1'b0; miss_address = 16'h0000;
        for (int i = 0; i < 40 && tag_cnt < 1; i++) tick();
        tick();
        checks++; if (req_log.size() != BW) begin failures++; $display("FAIL wrap_req_count got=%0d exp=%0d", req_log.size(), BW); end
        for (int k = 0; k < BW && k < req_log.size(); k++) begin
            e = exp_req.pop_front();
            checks++; if (req_log[k] !== e) begin failures++; $display("FAIL wrap_req[%0d] got=%h exp=%h", k, req_log[k], e); end
        end
        for (int k = 0; k < BW && k < wr_addr_log.size(); k++) begin
            e = exp_wr_addr.pop_front();
            checks++; if (wr_addr_log[k] !== e || wr_data_log[k] !== exp_wr_data[0]) begin
                failures++; $display("FAIL wrap_wr[%0d] got=%h/%h exp=%h/%h", k, wr_addr_log[k], wr_data_log[k], e, exp_wr_data[0]);
            end
            void'(exp_wr_data.pop_front());
        end
        checks++; if (tag_cnt != 1 || tag_at_wr != BW || last_busy !== 1'b0) begin
            failures++; $display("FAIL wrap_done got=tag%0d wr%0d busy%b exp=tag1 wr%0d busy0", tag_cnt, tag_at_wr, last_busy, BW);
        end
    endtask

`ifdef CACHE_FILL_TIMEOUT_EN
    task automatic test_timeout();
        int c0;
        clear_logs(); latency = 4; mem_budget = 2;
        c0 = cyc;
        miss_detected = 1'b1; miss_address = 16'h0100;
        tick();
        miss_detected = 1'b0; miss_address = 16'h0000;
        for (int i = 0; i < 80 && err_cnt < 1; i++) tick();
        tick();
        checks++; if (wr_addr_log.size() != 2) begin failures++; $display("FAIL timeout_words got=%0d exp=2", wr_addr_log.size()); end
        checks++; if (err_cnt != 1 || err_cyc != c0 + 38) begin
            failures++; $display("FAIL timeout_error got=cnt%0d@%0d exp=cnt1@%0d", err_cnt, err_cyc, c0 + 38);
        end
        checks++; if (tag_cnt != 0 || last_busy !== 1'b0) begin
            failures++; $display("FAIL timeout_state got=tag%0d busy%b exp=tag0 busy0", tag_cnt, last_busy);
        end
        mem_budget = -1;
        pend.delete();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_logs();
        test_reset();
        test_basic_fill();
        test_miss_held();
        test_idle_valid();
        test_reset_mid_fill();
        test_wrap();
`ifdef CACHE_FILL_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
